// File: rtl/divider_arbiter.sv
// divider_arbiter
//   Shares one pipelined, in-order divider between NUM_REQ requesters.
//   One request per cycle is chosen round-robin and issued to the divider.
//   Each issue pushes a tag {requester, zero_divisor} into an in-flight FIFO.
//   Each returning result pops the head tag and is steered back to that
//   requester. Zero-divisor results are replaced by quotient=all ones and
//   remainder=0.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   req_valid_in           per-requester request valid
//   req_dividend_in        packed dividends, requester i at [i*WIDTH +: WIDTH]
//   req_divisor_in         packed divisors, same packing
//   req_ready_out          one-hot grant (combinational)
//   div_dividend_out       registered operands to the divider
//   div_divisor_out
//   div_valid_out          issue strobe to the divider
//   div_quotient_in        result from the divider
//   div_remainder_in
//   div_valid_in           result strobe from the divider
//   resp_valid_out         one-hot single-cycle response strobe
//   resp_quotient_out      response data, held until the next response
//   resp_remainder_out
//   resp_div_zero_out      response belongs to a zero-divisor request
//   inflight_out           outstanding issue count
//   protocol_err_out       sticky: result arrived with no outstanding tag

module divider_arbiter #(
  parameter int WIDTH        = 9,
  parameter int NUM_REQ      = 2,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0]           req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0]           req_divisor_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic [WIDTH-1:0]                   div_dividend_out,
  output logic [WIDTH-1:0]                   div_divisor_out,
  output logic                               div_valid_out,
  input  logic [WIDTH-1:0]                   div_quotient_in,
  input  logic [WIDTH-1:0]                   div_remainder_in,
  input  logic                               div_valid_in,
  output logic [NUM_REQ-1:0]                 resp_valid_out,
  output logic [WIDTH-1:0]                   resp_quotient_out,
  output logic [WIDTH-1:0]                   resp_remainder_out,
  output logic                               resp_div_zero_out,
  output logic [$clog2(MAX_INFLIGHT):0]      inflight_out,
  output logic                               protocol_err_out
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = PW + 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               full;
  logic               transfer;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;
  logic               sel_zero;

  logic [CW-1:0]      count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [TW-1:0]      tag_mem [MAX_INFLIGHT];
  logic [TW-1:0]      head_tag;
  logic [PW-1:0]      head_req;
  logic               head_zero;

  // Requester index k positions after base, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  assign full = (count == CW'(MAX_INFLIGHT));

  // Walk the search order backwards so the requester closest to rr_ptr
  // is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (!full) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid_in[wrap_idx(rr_ptr, k)]) begin
          grant                       = '0;
          grant[wrap_idx(rr_ptr, k)]  = 1'b1;
          grant_idx                   = wrap_idx(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_dividend = req_dividend_in[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_zero      = (sel_divisor == '0);
  assign transfer      = |grant;
  assign push          = transfer;
  assign pop           = div_valid_in && (count != '0);
  assign req_ready_out = grant;
  assign inflight_out  = count;

  assign head_tag  = tag_mem[rd_ptr];
  assign head_req  = head_tag[TW-1:1];
  assign head_zero = head_tag[0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_valid_out    <= 1'b0;
      div_dividend_out <= '0;
      div_divisor_out  <= '0;
    end else begin
      div_valid_out <= transfer;
      if (transfer) begin
        div_dividend_out <= sel_dividend;
        div_divisor_out  <= sel_divisor;
      end
    end
  end

  // Tag storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk_in) begin
    if (push) tag_mem[wr_ptr] <= {grant_idx, sel_zero};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_valid_out     <= '0;
      resp_quotient_out  <= '0;
      resp_remainder_out <= '0;
      resp_div_zero_out  <= 1'b0;
      protocol_err_out   <= 1'b0;
    end else begin
      resp_valid_out <= '0;
      if (pop) begin
        resp_valid_out    <= NUM_REQ'(1) << head_req;
        resp_div_zero_out <= head_zero;
        if (head_zero) begin
          resp_quotient_out  <= '1;
          resp_remainder_out <= '0;
        end else begin
          resp_quotient_out  <= div_quotient_in;
          resp_remainder_out <= div_remainder_in;
        end
      end
      if (div_valid_in && (count == '0)) protocol_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter with a behavioural in-order divider of fixed
// latency that can be stalled, released a result at a time, or made to
// emit a spurious result.
module tb_divider_arbiter;

  localparam int WIDTH        = 9;
  localparam int NUM_REQ      = 2;
  localparam int MAX_INFLIGHT = 16;
  localparam int LAT          = 3;

  logic                     clk_in;
  logic                     rst_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
  logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [WIDTH-1:0]         div_dividend_out;
  logic [WIDTH-1:0]         div_divisor_out;
  logic                     div_valid_out;
  logic [WIDTH-1:0]         div_quotient_in;
  logic [WIDTH-1:0]         div_remainder_in;
  logic                     div_valid_in;
  logic [NUM_REQ-1:0]       resp_valid_out;
  logic [WIDTH-1:0]         resp_quotient_out;
  logic [WIDTH-1:0]         resp_remainder_out;
  logic                     resp_div_zero_out;
  logic [4:0]               inflight_out;
  logic                     protocol_err_out;

  divider_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_dividend_in(req_dividend_in),
    .req_divisor_in(req_divisor_in), .req_ready_out(req_ready_out),
    .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
    .div_valid_out(div_valid_out), .div_quotient_in(div_quotient_in),
    .div_remainder_in(div_remainder_in), .div_valid_in(div_valid_in),
    .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
    .resp_remainder_out(resp_remainder_out), .resp_div_zero_out(resp_div_zero_out),
    .inflight_out(inflight_out), .protocol_err_out(protocol_err_out)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               c;
  } op_t;

  typedef struct {
    logic [NUM_REQ-1:0] v;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    logic               dz;
  } resp_t;

  op_t   mq[$];
  resp_t rq[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit model_en     = 1'b1;
  int release_cnt  = 0;
  bit manual_pulse = 1'b0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Divider model: captures issues, returns results in order after LAT cycles.
  initial begin
    op_t op;
    div_valid_in     = 1'b0;
    div_quotient_in  = '0;
    div_remainder_in = '0;
    forever begin
      @(posedge clk_in);
      #1;
      cyc++;
      div_valid_in = 1'b0;
      if (rst_in) begin
        mq.delete();
      end else begin
        if (div_valid_out) begin
          op.a = div_dividend_out;
          op.b = div_divisor_out;
          op.c = cyc;
          mq.push_back(op);
        end
        if (manual_pulse) begin
          div_valid_in     = 1'b1;
          div_quotient_in  = 9'd7;
          div_remainder_in = 9'd7;
          manual_pulse     = 1'b0;
        end else if (mq.size() > 0 && (cyc - mq[0].c) >= LAT && (model_en || release_cnt > 0)) begin
          op = mq.pop_front();
          div_valid_in = 1'b1;
          if (op.b == 0) begin
            div_quotient_in  = 9'h055;
            div_remainder_in = 9'h033;
          end else begin
            div_quotient_in  = op.a / op.b;
            div_remainder_in = op.a % op.b;
          end
          if (!model_en) release_cnt--;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t rs;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in && resp_valid_out != 0) begin
        rs.v  = resp_valid_out;
        rs.q  = resp_quotient_out;
        rs.r  = resp_remainder_out;
        rs.dz = resp_div_zero_out;
        rq.push_back(rs);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk_in);
    rst_in       = 1'b1;
    req_valid_in = '0;
    model_en     = 1'b1;
    release_cnt  = 0;
    manual_pulse = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    rq.delete();
  endtask

  task automatic wait_resp(input int n, input int budget, input string name);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL %s_resp_timeout: got %0d responses expected %0d", name, rq.size(), n);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (div_valid_out !== 1'b0) begin errors++; $display("FAIL reset_div_valid: got %0b expected 0", div_valid_out); end
    checks++; if (div_dividend_out !== 9'd0) begin errors++; $display("FAIL reset_div_dividend: got %0d expected 0", div_dividend_out); end
    checks++; if (resp_valid_out !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %0b expected 00", resp_valid_out); end
    checks++; if (resp_quotient_out !== 9'd0) begin errors++; $display("FAIL reset_resp_q: got %0d expected 0", resp_quotient_out); end
    checks++; if (resp_div_zero_out !== 1'b0) begin errors++; $display("FAIL reset_dz: got %0b expected 0", resp_div_zero_out); end
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight_out); end
    checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", protocol_err_out); end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic test_single;
    resp_t rs;
    @(negedge clk_in);
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL single_inflight_before: got %0d expected 0", inflight_out); end
    req_valid_in = 2'b01;
    req_dividend_in[0 +: WIDTH] = 9'd64;
    req_divisor_in[0 +: WIDTH]  = 9'd40;
    #1;
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", req_ready_out); end
    @(negedge clk_in);
    req_valid_in = 2'b00;
    #1;
    checks++; if (div_valid_out !== 1'b1) begin errors++; $display("FAIL single_issue_valid: got %0b expected 1", div_valid_out); end
    checks++; if (div_dividend_out !== 9'd64) begin errors++; $display("FAIL single_issue_dividend: got %0d expected 64", div_dividend_out); end
    checks++; if (div_divisor_out !== 9'd40) begin errors++; $display("FAIL single_issue_divisor: got %0d expected 40", div_divisor_out); end
    checks++; if (inflight_out !== 5'd1) begin errors++; $display("FAIL single_inflight_one: got %0d expected 1", inflight_out); end
    @(negedge clk_in);
    #1;
    checks++; if (div_valid_out !== 1'b0) begin errors++; $display("FAIL single_issue_pulse: got %0b expected 0", div_valid_out); end
    checks++; if (div_dividend_out !== 9'd64) begin errors++; $display("FAIL single_issue_hold: got %0d expected 64", div_dividend_out); end
    wait_resp(1, 20, "single");
    rs = rq[0];
    checks++; if (rs.v !== 2'b01) begin errors++; $display("FAIL single_resp_valid: got %b expected 01", rs.v); end
    checks++; if (rs.q !== 9'd1) begin errors++; $display("FAIL single_resp_q: got %0d expected 1", rs.q); end
    checks++; if (rs.r !== 9'd24) begin errors++; $display("FAIL single_resp_r: got %0d expected 24", rs.r); end
    checks++; if (rs.dz !== 1'b0) begin errors++; $display("FAIL single_resp_dz: got %0b expected 0", rs.dz); end
    @(negedge clk_in);
    #1;
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL single_inflight_after: got %0d expected 0", inflight_out); end
    checks++; if (resp_valid_out !== 2'b00) begin errors++; $display("FAIL single_resp_pulse: got %b expected 00", resp_valid_out); end
    checks++; if (resp_quotient_out !== 9'd1) begin errors++; $display("FAIL single_resp_hold: got %0d expected 1", resp_quotient_out); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    do_reset();
    @(negedge clk_in);
    req_dividend_in[0 +: WIDTH]     = 9'd62;
    req_divisor_in[0 +: WIDTH]      = 9'd4;
    req_dividend_in[WIDTH +: WIDTH] = 9'd40;
    req_divisor_in[WIDTH +: WIDTH]  = 9'd4;
    req_valid_in = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_in);
      #1;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (req_ready_out !== exp_g) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready_out, exp_g); end
      if (k > 0) begin
        checks++; if (div_valid_out !== 1'b1) begin errors++; $display("FAIL rr_issue_%0d: got %0b expected 1", k, div_valid_out); end
      end
    end
    @(negedge clk_in);
    req_valid_in = 2'b00;
    #1;
    checks++; if (div_dividend_out !== 9'd40) begin errors++; $display("FAIL rr_last_issue: got %0d expected 40", div_dividend_out); end
    wait_resp(4, 30, "rr");
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (rq[k].v !== exp_g || rq[k].q !== ((k % 2 == 0) ? 9'd15 : 9'd10) || rq[k].r !== ((k % 2 == 0) ? 9'd2 : 9'd0)) begin
        errors++;
        $display("FAIL rr_resp_%0d: got v=%b q=%0d r=%0d expected v=%b q=%0d r=%0d", k, rq[k].v, rq[k].q, rq[k].r,
                 exp_g, (k % 2 == 0) ? 15 : 10, (k % 2 == 0) ? 2 : 0);
      end
    end
  endtask

  task automatic test_div_zero;
    do_reset();
    @(negedge clk_in);
    req_dividend_in[WIDTH +: WIDTH] = 9'd100;
    req_divisor_in[WIDTH +: WIDTH]  = 9'd0;
    req_valid_in = 2'b10;
    #1;
    checks++; if (req_ready_out !== 2'b10) begin errors++; $display("FAIL dz_grant: got %b expected 10", req_ready_out); end
    @(negedge clk_in);
    req_dividend_in[0 +: WIDTH] = 9'd40;
    req_divisor_in[0 +: WIDTH]  = 9'd4;
    req_valid_in = 2'b01;
    #1;
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL dz_grant2: got %b expected 01", req_ready_out); end
    @(negedge clk_in);
    req_valid_in = 2'b00;
    wait_resp(2, 20, "dz");
    checks++; if (rq[0].v !== 2'b10) begin errors++; $display("FAIL dz_resp_valid: got %b expected 10", rq[0].v); end
    checks++; if (rq[0].q !== 9'd511) begin errors++; $display("FAIL dz_resp_q: got %0d expected 511", rq[0].q); end
    checks++; if (rq[0].r !== 9'd0) begin errors++; $display("FAIL dz_resp_r: got %0d expected 0", rq[0].r); end
    checks++; if (rq[0].dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %0b expected 1", rq[0].dz); end
    checks++; if (rq[1].dz !== 1'b0 || rq[1].q !== 9'd10 || rq[1].v !== 2'b01) begin
      errors++; $display("FAIL dz_next_resp: got v=%b q=%0d dz=%0b expected v=01 q=10 dz=0", rq[1].v, rq[1].q, rq[1].dz);
    end
  endtask

  task automatic test_full;
    int bad;
    int k;
    do_reset();
    model_en = 1'b0;
    @(negedge clk_in);
    req_dividend_in[0 +: WIDTH] = 9'd20;
    req_divisor_in[0 +: WIDTH]  = 9'd3;
    req_valid_in = 2'b01;
    repeat (16) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    checks++; if (req_ready_out !== 2'b00) begin errors++; $display("FAIL full_no_grant: got %b expected 00", req_ready_out); end
    checks++; if (inflight_out !== 5'd16) begin errors++; $display("FAIL full_inflight: got %0d expected 16", inflight_out); end
    @(negedge clk_in);
    #1;
    checks++; if (div_valid_out !== 1'b0) begin errors++; $display("FAIL full_no_issue: got %0b expected 0", div_valid_out); end
    release_cnt = 2;
    @(negedge clk_in);
    #1;
    checks++; if (req_ready_out !== 2'b00) begin errors++; $display("FAIL full_no_bypass: got %b expected 00", req_ready_out); end
    checks++; if (inflight_out !== 5'd16) begin errors++; $display("FAIL full_pop_cycle_count: got %0d expected 16", inflight_out); end
    @(negedge clk_in);
    #1;
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL full_grant_after_pop: got %b expected 01", req_ready_out); end
    checks++; if (inflight_out !== 5'd15) begin errors++; $display("FAIL full_after_pop: got %0d expected 15", inflight_out); end
    @(negedge clk_in);
    #1;
    checks++; if (inflight_out !== 5'd15) begin errors++; $display("FAIL full_push_pop_same: got %0d expected 15", inflight_out); end
    @(negedge clk_in);
    #1;
    checks++; if (inflight_out !== 5'd16) begin errors++; $display("FAIL full_refilled: got %0d expected 16", inflight_out); end
    checks++; if (req_ready_out !== 2'b00) begin errors++; $display("FAIL full_refilled_grant: got %b expected 00", req_ready_out); end
    req_valid_in = 2'b00;
    model_en = 1'b1;
    wait_resp(18, 80, "full");
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      if (rq[i].v !== 2'b01 || rq[i].q !== 9'd6 || rq[i].r !== 9'd2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_resp_data: got %0d bad responses expected 0", bad); end
    k = 0;
    while (inflight_out != 0 && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", inflight_out); end
  endtask

  task automatic test_protocol_err;
    do_reset();
    @(negedge clk_in);
    #1;
    checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL perr_initial: got %0b expected 0", protocol_err_out); end
    manual_pulse = 1'b1;
    repeat (3) @(negedge clk_in);
    #1;
    checks++; if (protocol_err_out !== 1'b1) begin errors++; $display("FAIL perr_set: got %0b expected 1", protocol_err_out); end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL perr_no_resp: got %0d responses expected 0", rq.size()); end
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL perr_inflight: got %0d expected 0", inflight_out); end
    repeat (5) @(negedge clk_in);
    #1;
    checks++; if (protocol_err_out !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b expected 1", protocol_err_out); end
    do_reset();
    #1;
    checks++; if (protocol_err_out !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %0b expected 0", protocol_err_out); end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    @(negedge clk_in);
    req_dividend_in[0 +: WIDTH] = 9'd50;
    req_divisor_in[0 +: WIDTH]  = 9'd7;
    req_valid_in = 2'b01;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    req_valid_in = 2'b00;
    #1;
    checks++; if (inflight_out !== 5'd3) begin errors++; $display("FAIL mid_inflight3: got %0d expected 3", inflight_out); end
    rst_in = 1'b1;
    #1;
    checks++; if (div_valid_out !== 1'b0) begin errors++; $display("FAIL mid_div_valid: got %0b expected 0", div_valid_out); end
    checks++; if (div_dividend_out !== 9'd0 || div_divisor_out !== 9'd0) begin
      errors++; $display("FAIL mid_div_data: got %0d/%0d expected 0/0", div_dividend_out, div_divisor_out);
    end
    checks++; if (inflight_out !== 5'd0) begin errors++; $display("FAIL mid_inflight0: got %0d expected 0", inflight_out); end
    checks++; if (resp_valid_out !== 2'b00 || resp_quotient_out !== 9'd0 || resp_remainder_out !== 9'd0) begin
      errors++; $display("FAIL mid_resp: got v=%b q=%0d r=%0d expected 0", resp_valid_out, resp_quotient_out, resp_remainder_out);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    rq.delete();
    repeat (10) @(negedge clk_in);
    #1;
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d responses expected 0", rq.size()); end
    @(negedge clk_in);
    req_dividend_in[0 +: WIDTH] = 9'd40;
    req_divisor_in[0 +: WIDTH]  = 9'd4;
    req_valid_in = 2'b01;
    #1;
    checks++; if (req_ready_out !== 2'b01) begin errors++; $display("FAIL mid_grant: got %b expected 01", req_ready_out); end
    @(negedge clk_in);
    req_valid_in = 2'b00;
    wait_resp(1, 20, "mid");
    checks++; if (rq[0].v !== 2'b01 || rq[0].q !== 9'd10 || rq[0].r !== 9'd0) begin
      errors++; $display("FAIL mid_resp_data: got v=%b q=%0d r=%0d expected v=01 q=10 r=0", rq[0].v, rq[0].q, rq[0].r);
    end
  endtask

  initial begin
    rst_in          = 1'b1;
    req_valid_in    = '0;
    req_dividend_in = '0;
    req_divisor_in  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_full();
    test_protocol_err();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
